// File: rtl/clock_tick_ctrl.sv
// clock_tick_ctrl: seconds-enable prescaler, key debounce, mode select and
// run/pause control for the decade clock/calendar counter.
// Optional fast-tick key: define FAST_TICK_EN to add key_fast_n and FAST_DIV.
module clock_tick_ctrl #(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned TICK_HZ      = 1,
  parameter int unsigned DEBOUNCE_CYC = 1000000
`ifdef FAST_TICK_EN
  ,
  parameter int unsigned FAST_DIV     = 1000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_mode_n,
  input  logic key_run_n,
`ifdef FAST_TICK_EN
  input  logic key_fast_n,
`endif
  output logic sec_tick,
  output logic mode,
  output logic running,
  output logic blink
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

`ifdef FAST_TICK_EN
  localparam int unsigned NKEY  = 3;
`else
  localparam int unsigned NKEY  = 2;
`endif
  localparam int unsigned K_MODE = 0;
  localparam int unsigned K_RUN  = 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(DIV / 2);

`ifdef FAST_TICK_EN
  localparam int unsigned K_FAST = 2;
  // A fast divider larger than DIV would overflow the prescaler; cap it.
  localparam int unsigned FAST_DIV_EFF = (FAST_DIV < DIV) ? FAST_DIV : DIV;
  localparam logic [PRE_W-1:0] FAST_LAST = PRE_W'(FAST_DIV_EFF - 1);
  localparam logic [PRE_W-1:0] FAST_HALF = PRE_W'(FAST_DIV_EFF / 2);
`endif

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } state_e;

  logic [NKEY-1:0]  w_keys_n;
  logic [NKEY-1:0]  r_sync1;
  logic [NKEY-1:0]  r_sync2;
  logic [NKEY-1:0]  r_lvl;
  logic [NKEY-1:0]  r_lvl_d;
  logic [DB_W-1:0]  r_db_cnt [NKEY];
  logic [NKEY-1:0]  w_press;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [PRE_W-1:0] r_presc;
  logic [PRE_W-1:0] w_presc_nxt;
  logic [PRE_W-1:0] w_last;
  logic [PRE_W-1:0] w_half;
  logic             r_tick;
  logic             r_mode;
  logic             r_running;
  logic             r_blink;
  logic             w_tick_nxt;
  logic             w_mode_nxt;
  logic             w_blink_nxt;

`ifdef FAST_TICK_EN
  assign w_keys_n = {key_fast_n, key_run_n, key_mode_n};
  assign w_last   = r_lvl[K_FAST] ? PRE_LAST : FAST_LAST;
  assign w_half   = r_lvl[K_FAST] ? PRE_HALF : FAST_HALF;
`else
  assign w_keys_n = {key_run_n, key_mode_n};
  assign w_last   = PRE_LAST;
  assign w_half   = PRE_HALF;
`endif

  // Two-flop synchroniser and per-key stability counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_lvl   <= '1;
      r_lvl_d <= '1;
      for (int unsigned k = 0; k < NKEY; k++) begin
        r_db_cnt[k] <= '0;
      end
    end else begin
      r_sync1 <= w_keys_n;
      r_sync2 <= r_sync1;
      r_lvl_d <= r_lvl;
      for (int unsigned k = 0; k < NKEY; k++) begin
        if (r_sync2[k] == r_lvl[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_LAST) begin
          r_db_cnt[k] <= '0;
          r_lvl[k]    <= r_sync2[k];
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // Press = debounced falling edge; release is ignored
  assign w_press = r_lvl_d & ~r_lvl;

  // Run/pause state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next output values; the prescaler follows the current state
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_tick_nxt  = 1'b0;
    w_mode_nxt  = r_mode ^ w_press[K_MODE];
    case (r_state)
      ST_RUN: begin
        w_presc_nxt = (r_presc >= w_last) ? '0 : r_presc + PRE_W'(1);
        w_tick_nxt  = (w_presc_nxt >= w_last);
        if (w_press[K_RUN]) begin
          w_state_nxt = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (w_press[K_RUN]) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
    w_blink_nxt = (w_state_nxt == ST_RUN) && (w_presc_nxt < w_half);
  end

  // Registered prescaler and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc   <= '0;
      r_tick    <= 1'b0;
      r_mode    <= 1'b0;
      r_running <= 1'b1;
      r_blink   <= 1'b1;
    end else begin
      r_presc   <= w_presc_nxt;
      r_tick    <= w_tick_nxt;
      r_mode    <= w_mode_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_blink   <= w_blink_nxt;
    end
  end

  assign sec_tick = r_tick;
  assign mode     = r_mode;
  assign running  = r_running;
  assign blink    = r_blink;

endmodule

// File: tb/tb_clock_tick_ctrl.sv
// Bench for clock_tick_ctrl: per-cycle expected outputs are queued as each
// stimulus phase is driven and checked by a negedge monitor.
module tb_clock_tick_ctrl;

  localparam int DIV = 100;

  logic clk;
  logic rst_n;
  logic key_mode_n;
  logic key_run_n;
  logic key_fast_n;
  logic sec_tick;
  logic mode;
  logic running;
  logic blink;

  clock_tick_ctrl #(
    .CLK_HZ      (100),
    .TICK_HZ     (1),
    .DEBOUNCE_CYC(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_mode_n(key_mode_n),
    .key_run_n (key_run_n),
`ifdef FAST_TICK_EN
    .key_fast_n(key_fast_n),
`endif
    .sec_tick  (sec_tick),
    .mode      (mode),
    .running   (running),
    .blink     (blink)
  );

  typedef struct {
    int         cyc;
    logic [3:0] vec;   // {sec_tick, mode, running, blink}
    string      tag;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_err    = 0;
  int  cyc;
  int  tick_cnt;

  // Expected state, advanced one clock edge at a time
  int   e_cyc;
  int   e_presc;
  logic e_mode;
  logic e_run;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Rising edges since the last reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Pop and compare the expectation for the current cycle
  always @(negedge clk) begin
    sb_t e;
    if (rst_n) begin
      if (sec_tick === 1'b1) tick_cnt++;
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        e = sb_q.pop_front();
        chk({"missed_", e.tag}, 32'(cyc), 32'(e.cyc));
      end
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        chk($sformatf("%s@clk%0d", e.tag, cyc + 1), 32'({sec_tick, mode, running, blink}), 32'(e.vec));
      end
    end
  end

  // Queue expectations for the next n edges; a press takes effect on edge
  // mode_at / run_at of the window (0 = none)
  task automatic plan(input int n, input int mode_at, input int run_at, input string tag);
    sb_t  e;
    logic tk;
    logic bl;
    for (int i = 1; i <= n; i++) begin
      e_cyc++;
      tk = 1'b0;
      if (e_run) begin
        e_presc = (e_presc == DIV - 1) ? 0 : e_presc + 1;
        tk      = (e_presc == DIV - 1);
      end
      if (i == mode_at) e_mode = ~e_mode;
      if (i == run_at)  e_run  = ~e_run;
      bl = e_run && (e_presc < DIV / 2);
      e.cyc = e_cyc;
      e.vec = {tk, e_mode, e_run, bl};
      e.tag = tag;
      sb_q.push_back(e);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    e_cyc   = 0;
    e_presc = 0;
    e_mode  = 1'b0;
    e_run   = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tick"},    32'(sec_tick), 32'd0);
    chk({tag, "_mode"},    32'(mode),     32'd0);
    chk({tag, "_running"}, 32'(running),  32'd1);
    chk({tag, "_blink"},   32'(blink),    32'd1);
  endtask

  // Press one or both keys for 10 clocks, then release
  task automatic press(input logic pm, input logic pr, input int window,
                       input int mode_at, input int run_at, input string tag);
    plan(window, mode_at, run_at, tag);
    if (pm) key_mode_n = 1'b0;
    if (pr) key_run_n  = 1'b0;
    edges(10);
    key_mode_n = 1'b1;
    key_run_n  = 1'b1;
    edges(window - 10);
  endtask

  initial begin
    int k;
    rst_n      = 1'b0;
    key_mode_n = 1'b1;
    key_run_n  = 1'b1;
    key_fast_n = 1'b1;
    tick_cnt   = 0;
    model_reset();
    edges(3);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Free run: ticks on clocks 100/200/300, blink on clocks 1-50
    plan(350, 0, 0, "free_run");
    edges(350);
    chk("tick_count", 32'(tick_cnt), 32'd3);

    // Mode press and press again; toggle on the 6th edge after first low sample
    press(1'b1, 1'b0, 20, 7, 0, "mode_on");
    press(1'b1, 1'b0, 20, 7, 0, "mode_off");

    // Bouncing mode key never holds long enough
    plan(24, 0, 0, "bounce");
    for (int i = 0; i < 10; i++) begin
      key_mode_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      edges(2);
    end
    key_mode_n = 1'b1;
    edges(4);

    // Pause lands with prescaler = 40, hold 500 clocks, then resume
    k = (33 - e_presc + DIV) % DIV;
    if (k > 0) begin
      plan(k, 0, 0, "align40");
      edges(k);
    end
    press(1'b0, 1'b1, 500, 0, 7, "paused");
    press(1'b0, 1'b1, 80, 0, 7, "resumed");

    // Both keys together, then resume running
    press(1'b1, 1'b1, 20, 7, 7, "both");
    press(1'b0, 1'b1, 20, 0, 7, "rerun");

    // Asynchronous reset in the middle of a second (prescaler = 70)
    k = (70 - e_presc + DIV) % DIV;
    if (k > 0) begin
      plan(k, 0, 0, "align70");
      edges(k);
    end
    chk("pre_reset_mode", 32'(mode), 32'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    model_reset();
    edges(3);
    chk_reset_vals("held_reset");
    rst_n = 1'b1;
    tick_cnt = 0;
    plan(250, 0, 0, "post_reset");
    edges(250);
    chk("post_reset_ticks", 32'(tick_cnt), 32'd2);

    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running bench, want finished");
    $fatal(1, "time limit");
  end

endmodule
